// File: rtl/ps2_scan_rx_pkg.sv
// Shared types and constants for the PS/2 scancode receiver.
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } ps2_state_t;

   localparam logic [7:0] PS2_EXT = 8'hE0;
   localparam logic [7:0] PS2_REL = 8'hF0;

endpackage

// File: rtl/ps2_scan_rx_if.sv
// Scancode output bundle of the PS/2 receiver: FIFO head handshake plus status.
interface ps2_scan_rx_if #(
   parameter int FIFO_DEPTH = 8
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   // code_data is stable while code_valid=1; the head is consumed on any cycle
   // where code_valid and code_ready are both 1, and code_ready may be held high.
   logic [9:0]    code_data;
   logic          code_valid;
   logic          code_ready;
   logic [CW-1:0] fifo_count;
   logic          parity_err;
   logic          frame_err;
   logic          overflow;

   modport master (
      output code_data, code_valid, fifo_count, parity_err, frame_err, overflow,
      input  code_ready
   );

   modport slave (
      input  code_data, code_valid, fifo_count, parity_err, frame_err, overflow,
      output code_ready
   );

endinterface

// File: rtl/ps2_scan_rx_fifo.sv
// Small synchronous FIFO; the head word is read straight from storage.
module sync_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 8,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             overflow,
   output logic [AW:0]      count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wp, rp;
   logic             full, do_push, do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rp];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wp       <= '0;
         rp       <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         overflow <= push && !do_push;
         if (do_push) begin
            mem[wp] <= din;
            wp      <= wp + 1'b1;
         end
         if (do_pop) rp <= rp + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (!do_push && do_pop) count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: synchronise and deglitch the line, deframe bytes,
// fold E0/F0 prefixes into flags and queue the resulting scancodes.
module ps2_scan_rx
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN  = 4,
   parameter int TIMEOUT_CYC = 20000,
   parameter int FIFO_DEPTH  = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ps2_clk,
   input  logic         ps2_data,
   ps2_scan_rx_if.master bus,
   output ps2_state_t   state
);

   logic       clk_s1, clk_s2, dat_s1, dat_s2;
   logic       filt_clk, fall, bit_s;
   logic [3:0] fcnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_s1   <= 1'b1;
         clk_s2   <= 1'b1;
         dat_s1   <= 1'b1;
         dat_s2   <= 1'b1;
         filt_clk <= 1'b1;
         fcnt     <= '0;
         fall     <= 1'b0;
         bit_s    <= 1'b1;
      end else begin
         clk_s1 <= ps2_clk;
         clk_s2 <= clk_s1;
         dat_s1 <= ps2_data;
         dat_s2 <= dat_s1;
         fall   <= 1'b0;
         if (clk_s2 != filt_clk) begin
            if (fcnt == 4'(FILTER_LEN - 1)) begin
               filt_clk <= clk_s2;
               fcnt     <= '0;
               fall     <= !clk_s2;
               if (!clk_s2) bit_s <= dat_s2;
            end else begin
               fcnt <= fcnt + 1'b1;
            end
         end else begin
            fcnt <= '0;
         end
      end
   end

   logic [2:0] bcnt;
   logic [15:0] tcnt;
   logic [7:0] shreg;
   logic       par, ext, rel, push, parity_err, frame_err;
   logic [9:0] push_code;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         bcnt       <= '0;
         tcnt       <= '0;
         shreg      <= '0;
         par        <= 1'b0;
         ext        <= 1'b0;
         rel        <= 1'b0;
         push       <= 1'b0;
         push_code  <= '0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         push       <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         if (state == IDLE || fall) tcnt <= '0;
         else                       tcnt <= tcnt + 1'b1;

         if (state != IDLE && !fall && tcnt == 16'(TIMEOUT_CYC - 1)) begin
            state     <= IDLE;
            frame_err <= 1'b1;
            ext       <= 1'b0;
            rel       <= 1'b0;
         end else if (fall) begin
            case (state)
               IDLE: begin
                  if (!bit_s) begin
                     state <= DATA;
                     bcnt  <= '0;
                  end
               end
               DATA: begin
                  shreg <= {bit_s, shreg[7:1]};
                  bcnt  <= bcnt + 1'b1;
                  if (bcnt == 3'd7) state <= PARITY;
               end
               PARITY: begin
                  par   <= bit_s;
                  state <= STOP;
               end
               STOP: begin
                  state <= IDLE;
                  // Parity takes precedence when parity and stop are both bad.
                  if (!(^shreg ^ par)) begin
                     parity_err <= 1'b1;
                     ext        <= 1'b0;
                     rel        <= 1'b0;
                  end else if (!bit_s) begin
                     frame_err <= 1'b1;
                     ext       <= 1'b0;
                     rel       <= 1'b0;
                  end else if (shreg == PS2_EXT) begin
                     ext <= 1'b1;
                  end else if (shreg == PS2_REL) begin
                     rel <= 1'b1;
                  end else begin
                     push      <= 1'b1;
                     push_code <= {ext, rel, shreg};
                     ext       <= 1'b0;
                     rel       <= 1'b0;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   logic fifo_empty;

   sync_fifo #(.WIDTH(10), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .din      (push_code),
      .pop      (bus.code_ready),
      .dout     (bus.code_data),
      .empty    (fifo_empty),
      .overflow (bus.overflow),
      .count    (bus.fifo_count)
   );

   assign bus.code_valid = !fifo_empty;
   assign bus.parity_err = parity_err;
   assign bus.frame_err  = frame_err;

endmodule

// File: doc/ps2_scan_rx.md
PS2_SCAN_RX -- requirements
Module: ps2_scan_rx

Interface
REQ-001 Parameter FILTER_LEN, default 4: clk cycles the synchronised ps2_clk must hold a new level before the filtered clock follows it; range 1..15.
REQ-002 Parameter TIMEOUT_CYC, default 20000: clk cycles allowed between falling edges inside a frame before the frame aborts; range 16..65535.
REQ-003 Parameter FIFO_DEPTH, default 8: scancode FIFO entries; power of two, range 2..64.
REQ-004 clk  input  1  system clock; the only clock in the block.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 ps2_clk  input  1  raw PS/2 clock from the device, asynchronous to clk.
REQ-007 ps2_data  input  1  raw PS/2 data, asynchronous to clk.
REQ-008 code_data  output  10  FIFO head as {extend, release, byte[7:0]}.
REQ-009 code_valid  output  1  FIFO not empty; code_data is meaningful.
REQ-010 code_ready  input  1  consumer pops the head on a cycle where code_valid=1 and code_ready=1.
REQ-011 fifo_count  output  clog2(FIFO_DEPTH)+1  number of stored entries.
REQ-012 parity_err  output  1  one-cycle pulse per frame rejected for parity.
REQ-013 frame_err  output  1  one-cycle pulse per frame rejected for a stop bit of 0 or a timeout.
REQ-014 overflow  output  1  one-cycle pulse per completed code dropped because the FIFO was full.

Function
REQ-015 ps2_clk and ps2_data SHALL each pass through a 2-flop synchroniser before any other logic uses them.
REQ-016 Filtered clock SHALL change level only after the synchronised ps2_clk has differed from it for FILTER_LEN consecutive cycles; each 1->0 change produces one edge strobe.
REQ-017 On each edge strobe, the synchronised ps2_data SHALL be sampled; all frame logic uses only this sample.
REQ-018 FSM states: IDLE, DATA, PARITY, STOP.
- IDLE: sample 0 -> DATA; sample 1 is ignored.
- DATA: 8 samples, LSB first -> PARITY.
- PARITY: store the sample -> STOP.
- STOP: evaluate the frame -> IDLE.
REQ-019 Parity SHALL be odd: XOR of the 8 data bits and the parity bit must equal 1, otherwise pulse parity_err and discard the frame.
REQ-020 A stop sample of 0 SHALL pulse frame_err and discard the frame; when parity and stop are both bad, only parity_err pulses.
REQ-021 Timeout counter SHALL clear on every edge strobe and in IDLE; reaching TIMEOUT_CYC outside IDLE -> IDLE, frame_err pulse, partial byte discarded.
REQ-022 Valid byte 8'hE0 SHALL set the extend flag; valid byte 8'hF0 SHALL set the release flag; neither pushes.
REQ-023 Any other valid byte SHALL push {extend, release, byte} and clear both flags in the same cycle.
REQ-024 Any discarded frame (parity error, frame error or timeout) SHALL also clear both prefix flags.
REQ-025 Latency: the STOP edge strobe is at cycle E; the push occurs at cycle E+1 and code_valid is 1 at E+2 if the FIFO was empty.
REQ-026 Push when full with no pop SHALL drop the code and pulse overflow; FIFO contents are unchanged.
REQ-027 Push and pop in the same cycle SHALL both take effect, including when full (no overflow) and when holding one entry; fifo_count is unchanged.
REQ-028 Pop when empty SHALL have no effect; read and write pointers wrap modulo FIFO_DEPTH.
REQ-029 code_data SHALL be driven from the FIFO head storage, with no combinational path from ps2 inputs.

Reset
REQ-030 On rst, all of the following SHALL clear asynchronously:
- FSM -> IDLE; synchronisers, filter and filtered clock -> 1;
- bit counter, timeout counter and prefix flags -> 0;
- FIFO pointers -> 0; fifo_count=0; code_valid=0; code_data=0;
- parity_err, frame_err, overflow -> 0.
REQ-031 Reset mid-frame SHALL discard the partial frame; no error pulse occurs after release.

Structure
REQ-032 Shared package ps2_pkg SHALL hold the FSM state enum and the constants PS2_EXT=8'hE0 and PS2_REL=8'hF0.
REQ-033 The FIFO SHALL be the sub-module sync_fifo (parameters WIDTH=10, DEPTH), with its own push/pop/full/empty/count.

Verification
REQ-034 Valid frame for byte 8'h1C (parity bit 0) -> exactly one entry code_data=10'h01C, code_valid at E+2, fifo_count=1.
REQ-035 Frames E0, F0, 75 -> one entry code_data=10'h375; then frame 75 alone -> 10'h075.
REQ-036 Frame 8'h1C with parity bit 1 -> parity_err pulse, no push; a following F0, 1C -> 10'h11C; a glitch shorter than FILTER_LEN on ps2_clk produces no edge strobe.
REQ-037 Stop ps2_clk after the 4th data bit for TIMEOUT_CYC cycles -> frame_err pulse, FSM IDLE; the next valid frame 8'h29 -> 10'h029.
REQ-038 With code_ready=0, send FIFO_DEPTH+1 codes -> fifo_count=FIFO_DEPTH and one overflow pulse; then a full-FIFO push plus pop in the same cycle -> no overflow and count unchanged.
REQ-039 Assert rst mid-frame after 3 data bits -> all outputs 0 immediately; the next full valid frame is received correctly.
